input_mapper: RTL and testbench

Generalised player-input front end between hps_io (ps2_key, joystick_N) and the core's per-player joystick ports. Replaces hard-coded PS/2 scan-code decoding with a runtime-loadable key map covering NUM_PLAYERS players, NUM_BUTTONS buttons and E0-extended keys. Adds per-button autofire, a coin pulse stretcher and a state-clear input. Registered outputs, single clock domain (clk_sys).

---
 rtl/input_mapper_pkg.sv | 48 ++++
 rtl/input_mapper_keymap_ram.sv | 28 ++
 rtl/input_mapper.sv | 215 +++++++++++++++++++++
 tb/tb_input_mapper.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_mapper_pkg.sv
// Shared constants, function-index helpers and key-map entry type for the
// player input front end.
package input_pkg;

    localparam int FN_RIGHT  = 0;
    localparam int FN_LEFT   = 1;
    localparam int FN_DOWN   = 2;
    localparam int FN_UP     = 3;
    localparam int MAP_AW    = 9;

    // Player vector width for a given fire-button count.
    function automatic int calc_w(input int num_buttons);
        return num_buttons + 8;
    endfunction

    // Width of the player field in a key-map entry.
    function automatic int calc_pw(input int num_players);
        return (num_players <= 1) ? 1 : $clog2(num_players);
    endfunction

    function automatic int fn_button(input int i);
        return 4 + i;
    endfunction

    function automatic int fn_start(input int num_buttons);
        return 4 + num_buttons;
    endfunction

    function automatic int fn_coin(input int num_buttons);
        return 5 + num_buttons;
    endfunction

    function automatic int fn_pause(input int num_buttons);
        return 6 + num_buttons;
    endfunction

    function automatic int fn_service(input int num_buttons);
        return 7 + num_buttons;
    endfunction

    // Decoded key-map entry; player is wide enough for up to four players.
    typedef struct packed {
        logic       valid;
        logic [1:0] player;
        logic [3:0] fn;
    } keymap_entry_t;

endpackage

// File: rtl/input_mapper_keymap_ram.sv
// 512-entry simple dual-port key-map RAM. Registered read returns the old
// contents when the write and read addresses collide.
module keymap_ram #(
    parameter int DW = 6,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Write port plus registered read (read sees pre-write data).
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/input_mapper.sv
// Player-input front end: runtime key map for PS/2 events, merge with
// hps_io joysticks, per-button autofire and coin pulse stretching.
module input_mapper
    import input_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int NUM_BUTTONS     = 3,
    parameter int AUTOFIRE_DIV    = 500000,
    parameter int COIN_MIN_CYCLES = 1000000
) (
    input  logic                                    clk_sys,
    input  logic                                    reset_n,
    input  logic [10:0]                             ps2_key,
    input  logic [NUM_PLAYERS*(NUM_BUTTONS+8)-1:0]  joystick,
    input  logic                                    map_wr,
    input  logic [8:0]                              map_addr,
    input  logic [calc_pw(NUM_PLAYERS)+4:0]         map_data,
    input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0]      autofire_en,
    input  logic                                    clear,
    output logic                                    ready,
    output logic [NUM_PLAYERS*(NUM_BUTTONS+8)-1:0]  player
);

    localparam int W      = calc_w(NUM_BUTTONS);
    localparam int PW     = calc_pw(NUM_PLAYERS);
    localparam int DW     = 1 + PW + 4;
    localparam int NV     = NUM_PLAYERS * W;
    localparam int IDX_W  = $clog2(NV);
    localparam int CNT_W  = $clog2(AUTOFIRE_DIV);
    localparam int COIN_W = $clog2(COIN_MIN_CYCLES + 1);
    localparam int FB     = fn_button(0);
    localparam int FS     = fn_start(NUM_BUTTONS);
    localparam int FC     = fn_coin(NUM_BUTTONS);
    localparam int FP     = fn_pause(NUM_BUTTONS);
    localparam int FV     = fn_service(NUM_BUTTONS);

    typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [8:0]          r_init_cnt;
    logic                r_ready;
    logic                w_ram_we;
    logic [8:0]          w_ram_waddr;
    logic [DW-1:0]       w_ram_wdata;
    logic [DW-1:0]       w_ram_rdata;
    logic                r_toggle;
    logic                r_evt_valid;
    logic                r_evt_pressed;
    logic                w_event;
    keymap_entry_t       w_entry;
    logic                w_hit;
    logic [IDX_W-1:0]    w_key_idx;
    logic [NV-1:0]       r_keys;
    logic [NV-1:0]       w_raw;
    logic [NV-1:0]       w_merged;
    logic [NV-1:0]       r_player;
    logic [CNT_W-1:0]    r_af_cnt;
    logic                r_af_phase;

    keymap_ram #(.DW(DW), .AW(MAP_AW)) u_keymap_ram (
        .clk     (clk_sys),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (ps2_key[8:0]),
        .o_rdata (w_ram_rdata)
    );

    // Next-state logic and RAM write-port steering (INIT sweep vs host writes).
    always_comb begin
        w_state_next = r_state;
        w_ram_we     = 1'b0;
        w_ram_waddr  = map_addr;
        w_ram_wdata  = map_data;
        case (r_state)
            ST_INIT: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_init_cnt;
                w_ram_wdata = {DW{1'b0}};
                if (r_init_cnt == 9'd511) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_INIT;
                end
            end
            ST_IDLE: begin
                w_ram_we = map_wr;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // State register, init sweep address and ready flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= 9'd0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= (r_state == ST_INIT) ? r_init_cnt + 9'd1 : 9'd0;
            r_ready    <= (w_state_next == ST_IDLE);
        end
    end

    // Key events are only accepted once the map has been cleared.
    assign w_event = (ps2_key[10] != r_toggle) && (r_state == ST_IDLE);

    // Toggle history and event pipeline aligned with the RAM read latency.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_toggle      <= 1'b0;
            r_evt_valid   <= 1'b0;
            r_evt_pressed <= 1'b0;
        end else begin
            r_toggle      <= ps2_key[10];
            r_evt_valid   <= w_event;
            r_evt_pressed <= ps2_key[9];
        end
    end

    // Decode the looked-up entry and filter out unusable targets.
    always_comb begin
        w_entry.valid  = w_ram_rdata[DW-1];
        w_entry.player = 2'(w_ram_rdata[4 +: PW]);
        w_entry.fn     = w_ram_rdata[3:0];
        w_hit          = 1'b0;
        w_key_idx      = {IDX_W{1'b0}};
        if (r_evt_valid && w_entry.valid &&
            (int'(w_entry.player) < NUM_PLAYERS) && (int'(w_entry.fn) < W)) begin
            w_hit     = 1'b1;
            w_key_idx = IDX_W'(int'(w_entry.player) * W + int'(w_entry.fn));
        end else begin
            w_hit     = 1'b0;
        end
    end

    // Key state: clear has priority over a same-cycle event update.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_keys <= {NV{1'b0}};
        end else if (clear) begin
            r_keys <= {NV{1'b0}};
        end else if (w_hit) begin
            r_keys[w_key_idx] <= r_evt_pressed;
        end
    end

    // Free-running autofire divider; phase flips on every wrap.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt   <= {CNT_W{1'b0}};
            r_af_phase <= 1'b0;
        end else if (r_af_cnt == CNT_W'(AUTOFIRE_DIV - 1)) begin
            r_af_cnt   <= {CNT_W{1'b0}};
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + CNT_W'(1);
        end
    end

    assign w_raw = r_keys | joystick;

    for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_player
        logic [COIN_W-1:0] r_coin_cnt;
        logic              r_coin_prev;
        logic              w_coin_raw;

        assign w_coin_raw = w_raw[gp*W + FC];

        // Coin stretcher: (re)load on a raw rising edge, then count down.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_coin_cnt  <= {COIN_W{1'b0}};
                r_coin_prev <= 1'b0;
            end else begin
                r_coin_prev <= w_coin_raw;
                if (clear) begin
                    r_coin_cnt <= {COIN_W{1'b0}};
                end else if (w_coin_raw && !r_coin_prev) begin
                    r_coin_cnt <= COIN_W'(COIN_MIN_CYCLES);
                end else if (r_coin_cnt != {COIN_W{1'b0}}) begin
                    r_coin_cnt <= r_coin_cnt - COIN_W'(1);
                end
            end
        end

        assign w_merged[gp*W +: 4] = w_raw[gp*W +: 4];
        for (genvar gb = 0; gb < NUM_BUTTONS; gb++) begin : g_btn
            assign w_merged[gp*W + FB + gb] = autofire_en[gp*NUM_BUTTONS + gb]
                ? (w_raw[gp*W + FB + gb] & r_af_phase)
                : w_raw[gp*W + FB + gb];
        end
        assign w_merged[gp*W + FS] = w_raw[gp*W + FS];
        assign w_merged[gp*W + FC] = w_coin_raw | (r_coin_cnt != {COIN_W{1'b0}});
        assign w_merged[gp*W + FP] = w_raw[gp*W + FP];
        assign w_merged[gp*W + FV] = w_raw[gp*W + FV];
    end

    // Single output register after the merge stage.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_player <= {NV{1'b0}};
        end else begin
            r_player <= w_merged;
        end
    end

    assign ready  = r_ready;
    assign player = r_player;

endmodule

// File: tb/tb_input_mapper.sv
// Directed self-checking bench for input_mapper (2 players, 3 buttons,
// short autofire and coin timings).
module tb_input_mapper;

    localparam int W  = 11;
    localparam int NV = 22;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic [10:0]   ps2_key;
    logic [NV-1:0] joystick;
    logic          map_wr;
    logic [8:0]    map_addr;
    logic [5:0]    map_data;
    logic [5:0]    autofire_en;
    logic          clear;
    logic          ready;
    logic [NV-1:0] player;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    input_mapper #(
        .NUM_PLAYERS(2), .NUM_BUTTONS(3), .AUTOFIRE_DIV(4), .COIN_MIN_CYCLES(10)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick(joystick), .map_wr(map_wr), .map_addr(map_addr),
        .map_data(map_data), .autofire_en(autofire_en), .clear(clear),
        .ready(ready), .player(player)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_key(input logic ext, input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic map_write(input logic [8:0] a, input logic [5:0] d);
        map_wr   = 1'b1;
        map_addr = a;
        map_data = d;
        tick(1);
        map_wr   = 1'b0;
    endtask

    task automatic test_reset;
        int first_hi;
        logic nz;
        reset_n = 1'b0; ps2_key = 11'd0; joystick = '0; map_wr = 1'b0;
        map_addr = 9'd0; map_data = 6'd0; autofire_en = 6'd0; clear = 1'b0;
        tick(3);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL reset_player got=%h exp=0", player); end
        reset_n = 1'b1;
        first_hi = -1;
        nz = 1'b0;
        for (int i = 1; i <= 520; i++) begin
            tick(1);
            if (ready === 1'b1 && first_hi < 0) first_hi = i;
            if (player !== 22'd0) nz = 1'b1;
        end
        checks++;
        if (first_hi !== 512) begin errors++; $display("FAIL init_length got=%0d exp=512", first_hi); end
        checks++;
        if (nz !== 1'b0) begin errors++; $display("FAIL init_player_zero got=%b exp=0", nz); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_hold got=%b exp=1", ready); end
    endtask

    task automatic test_key_map;
        send_key(1'b0, 8'h75, 1'b1);
        tick(3);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL unmapped_after_init got=%h exp=0", player); end
        send_key(1'b0, 8'h75, 1'b0);
        tick(3);
        map_write(9'h075, {1'b1, 1'b0, 4'd3});
        send_key(1'b0, 8'h75, 1'b1);
        tick(2);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL up_latency got=%h exp=0", player); end
        tick(1);
        checks++;
        if (player !== 22'h000008) begin errors++; $display("FAIL up_press got=%h exp=000008", player); end
        send_key(1'b0, 8'h75, 1'b1);
        tick(3);
        checks++;
        if (player !== 22'h000008) begin errors++; $display("FAIL up_repress got=%h exp=000008", player); end
        send_key(1'b0, 8'h75, 1'b0);
        tick(3);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL up_release got=%h exp=0", player); end
        send_key(1'b1, 8'h75, 1'b1);
        tick(3);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL ext_unmapped got=%h exp=0", player); end
        send_key(1'b1, 8'h75, 1'b0);
        tick(3);
    endtask

    task automatic test_ext_player1;
        map_write(9'h16B, {1'b1, 1'b1, 4'd1});
        send_key(1'b1, 8'h6B, 1'b1);
        tick(3);
        checks++;
        if (player !== 22'h001000) begin errors++; $display("FAIL p1_left got=%h exp=001000", player); end
        send_key(1'b1, 8'h6B, 1'b0);
        tick(3);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL p1_left_release got=%h exp=0", player); end
        map_write(9'h020, {1'b1, 1'b0, 4'd12});
        send_key(1'b0, 8'h20, 1'b1);
        tick(3);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL fn_out_of_range got=%h exp=0", player); end
        send_key(1'b0, 8'h20, 1'b0);
        tick(3);
    endtask

    task automatic test_clear;
        send_key(1'b0, 8'h75, 1'b1);
        tick(3);
        checks++;
        if (player !== 22'h000008) begin errors++; $display("FAIL pre_clear got=%h exp=000008", player); end
        clear = 1'b1;
        send_key(1'b1, 8'h6B, 1'b1);
        tick(2);
        clear = 1'b0;
        tick(2);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL clear_wins got=%h exp=0", player); end
        send_key(1'b1, 8'h6B, 1'b1);
        tick(3);
        checks++;
        if (player !== 22'h001000) begin errors++; $display("FAIL map_kept_after_clear got=%h exp=001000", player); end
        send_key(1'b1, 8'h6B, 1'b0);
        tick(3);
        send_key(1'b0, 8'h75, 1'b0);
        tick(3);
    endtask

    task automatic test_autofire;
        logic prev;
        logic found;
        autofire_en = 6'b000001;
        joystick    = '0;
        joystick[4] = 1'b1;
        prev  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                tick(1);
                if (player[4] && !prev) found = 1'b1;
                prev = player[4];
            end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL autofire_edge got=%b exp=1", found); end
        for (int i = 1; i < 16; i++) begin
            tick(1);
            checks++;
            if (player[4] !== ((i % 8) < 4)) begin
                errors++;
                $display("FAIL autofire_wave[%0d] got=%b exp=%b", i, player[4], ((i % 8) < 4));
            end
        end
        autofire_en = 6'd0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (player[4] !== 1'b1) begin errors++; $display("FAIL autofire_off[%0d] got=%b exp=1", i, player[4]); end
        end
        joystick = '0;
        tick(2);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL autofire_idle got=%h exp=0", player); end
    endtask

    task automatic test_coin;
        for (int j = 0; j <= 12; j++) begin
            joystick[8] = (j == 0);
            tick(1);
            checks++;
            if (player[8] !== (j <= 10)) begin errors++; $display("FAIL coin_single[%0d] got=%b exp=%b", j, player[8], (j <= 10)); end
        end
        for (int j = 0; j <= 18; j++) begin
            joystick[8] = (j == 0 || j == 5);
            tick(1);
            checks++;
            if (player[8] !== (j <= 15)) begin errors++; $display("FAIL coin_retrig[%0d] got=%b exp=%b", j, player[8], (j <= 15)); end
        end
        joystick = '0;
        tick(1);
    endtask

    task automatic test_collision;
        map_wr   = 1'b1;
        map_addr = 9'h005;
        map_data = {1'b1, 1'b0, 4'd7};
        send_key(1'b0, 8'h05, 1'b1);
        tick(1);
        map_wr = 1'b0;
        tick(2);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL collision_old_entry got=%h exp=0", player); end
        send_key(1'b0, 8'h05, 1'b1);
        tick(3);
        checks++;
        if (player !== 22'h000080) begin errors++; $display("FAIL collision_next_event got=%h exp=000080", player); end
        send_key(1'b0, 8'h05, 1'b0);
        tick(3);
        checks++;
        if (player !== 22'd0) begin errors++; $display("FAIL start_release got=%h exp=0", player); end
    endtask

    initial begin
        test_reset();
        test_key_map();
        test_ext_player1();
        test_clear();
        test_autofire();
        test_coin();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
